// File: rtl/debug_unit_ctrl.sv
// Debug command sequencer: pops command bytes from the UART receive FIFO,
// runs or single-steps the pipeline, then triggers a debug dump and waits for it.
module debug_unit_ctrl #(
  parameter logic [7:0]  CMD_RUN  = 8'h43,
  parameter logic [7:0]  CMD_STEP = 8'h53,
  parameter logic [7:0]  CMD_DUMP = 8'h44,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] MAX_RUN  = 32'd1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [7:0]       r_data,
  output logic             rd_uart,
  input  logic             cpu_halt,
  output logic             cpu_en,
  output logic             send_signal,
  input  logic             data_sent,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted,
  output logic             cmd_error,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    RUN    = 3'd3,
    STEP   = 3'd4,
    SEND   = 3'd5,
    WAIT   = 3'd6
  } stateT;

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN - 32'd1);

  stateT            stateQ;
  stateT            stateD;
  logic [7:0]       cmdQ;
  logic [CNT_W-1:0] runCnt;
  logic [CNT_W-1:0] cycleCnt;
  logic             haltedQ;
  logic             cmdIsRun;
  logic             cmdIsStep;
  logic             cmdIsDump;

  assign cmdIsRun  = (cmdQ == CMD_RUN);
  assign cmdIsStep = (cmdQ == CMD_STEP);
  assign cmdIsDump = (cmdQ == CMD_DUMP);

  // FIFO handshake: r_data is valid whenever rx_empty=0 (show-ahead); the byte
  // is consumed on the edge where rd_uart=1, which only happens in FETCH.
  assign rd_uart     = (stateQ == FETCH);
  assign cpu_en      = (stateQ == RUN) || (stateQ == STEP);
  assign send_signal = (stateQ == SEND);
  assign cmd_error   = (stateQ == DECODE) && !(cmdIsRun || cmdIsStep || cmdIsDump);
  assign cycle_count = cycleCnt;
  assign halted      = haltedQ;
  assign state       = stateQ;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:   if (!rx_empty) stateD = FETCH;
      FETCH:  stateD = DECODE;
      DECODE: begin
        if (cmdIsDump)
          stateD = SEND;
        else if (cmdIsRun || cmdIsStep)
          // A finished program is never restarted; just dump its state.
          stateD = haltedQ ? SEND : (cmdIsRun ? RUN : STEP);
        else
          stateD = IDLE;
      end
      RUN:    if (cpu_halt || (runCnt == RUN_LAST)) stateD = SEND;
      STEP:   stateD = SEND;
      SEND:   stateD = WAIT;
      WAIT:   if (data_sent) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmdQ     <= 8'd0;
      runCnt   <= '0;
      cycleCnt <= '0;
      haltedQ  <= 1'b0;
    end else begin
      if (stateQ == FETCH) cmdQ <= r_data;
      if (stateQ == DECODE)
        runCnt <= '0;
      else if (stateQ == RUN)
        runCnt <= runCnt + 1'b1;
      if (cpu_en && (cycleCnt != '1)) cycleCnt <= cycleCnt + 1'b1;
      if (cpu_en && cpu_halt) haltedQ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Bench for debug_unit_ctrl: modelled receive FIFO and dump transmitter,
// table of command vectors plus directed reset sequences.
module tb_debug_unit_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_empty;
  logic [7:0]       r_data;
  logic             rd_uart;
  logic             cpu_halt;
  logic             cpu_en;
  logic             send_signal;
  logic             data_sent;
  logic [CNT_W-1:0] cycle_count;
  logic             halted;
  logic             cmd_error;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  debug_unit_ctrl #(
    .CMD_RUN (8'h43),
    .CMD_STEP(8'h53),
    .CMD_DUMP(8'h44),
    .CNT_W   (CNT_W),
    .MAX_RUN (32'd16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .cpu_halt   (cpu_halt),
    .cpu_en     (cpu_en),
    .send_signal(send_signal),
    .data_sent  (data_sent),
    .cycle_count(cycle_count),
    .halted     (halted),
    .cmd_error  (cmd_error),
    .state      (state)
  );

  // receive FIFO model: the bench pushes, the DUT pops
  logic [7:0] pushBuf [64];
  int pushCount = 0;
  int popIdx = 0;
  assign rx_empty = (popIdx == pushCount);
  assign r_data   = pushBuf[popIdx % 64];
  always @(posedge clk) if (rd_uart) popIdx <= popIdx + 1;

  // activity monitor and transmitter model
  int cyc = 0, rdCnt = 0, enCnt = 0, sendCnt = 0, errCnt = 0;
  int fetchIdx = 0, sendIdx = 0, sentCd = 0;
  logic sentPulse = 1'b0;
  logic manualSent = 1'b0;
  logic autoSent = 1'b1;
  int haltAt = 0;
  int enBase = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart) begin rdCnt <= rdCnt + 1; fetchIdx <= cyc; end
    if (cpu_en) enCnt <= enCnt + 1;
    if (send_signal) begin sendCnt <= sendCnt + 1; sendIdx <= cyc; end
    if (cmd_error) errCnt <= errCnt + 1;
    if (send_signal && autoSent) sentCd <= 3;
    else if (sentCd != 0) sentCd <= sentCd - 1;
    sentPulse <= (sentCd == 1);
  end

  assign data_sent = sentPulse | manualSent;
  // cpu_halt is raised during the haltAt-th enabled cycle of the current vector
  assign cpu_halt = cpu_en && (haltAt != 0) && ((enCnt - enBase) == haltAt);

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    pushBuf[pushCount % 64] = b;
    pushCount++;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         haltAt;
    bit         doReset;
    int         expRd;
    int         expEn;
    int         expSend;
    int         expErr;
    logic       expHalted;
    int         expCycles;
    int         expLat;
  } vecT;

  vecT vecs [10];

  task automatic runVector(input int i);
    int rd0, en0, send0, err0;
    if (vecs[i].doReset) applyReset();
    @(negedge clk);
    rd0 = rdCnt; en0 = enCnt; send0 = sendCnt; err0 = errCnt;
    enBase = enCnt;
    haltAt = vecs[i].haltAt;
    pushByte(vecs[i].cmd);
    repeat (40) @(negedge clk);
    haltAt = 0;
    check($sformatf("v%0d_rd_uart", i), rdCnt - rd0, vecs[i].expRd);
    check($sformatf("v%0d_cpu_en", i), enCnt - en0, vecs[i].expEn);
    check($sformatf("v%0d_send", i), sendCnt - send0, vecs[i].expSend);
    check($sformatf("v%0d_cmd_error", i), errCnt - err0, vecs[i].expErr);
    check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].expHalted});
    check($sformatf("v%0d_cycle_count", i), cycle_count, vecs[i].expCycles);
    check($sformatf("v%0d_state", i), {29'd0, state}, 32'd0);
    if (vecs[i].expLat != 0)
      check($sformatf("v%0d_latency", i), sendIdx - fetchIdx, vecs[i].expLat);
  endtask

  initial begin
    int n;
    int rd0, send0;
    for (int k = 0; k < 64; k++) pushBuf[k] = 8'h00;

    // cmd, haltAt, doReset, rd, en, send, err, halted, cycle_count, fetch->send
    vecs[0] = '{8'h44, 0,  1'b0, 1, 0,  1, 0, 1'b0, 0,  2};
    vecs[1] = '{8'h53, 0,  1'b0, 1, 1,  1, 0, 1'b0, 1,  3};
    vecs[2] = '{8'h5A, 0,  1'b0, 1, 0,  0, 1, 1'b0, 1,  0};
    vecs[3] = '{8'h43, 0,  1'b0, 1, 16, 1, 0, 1'b0, 17, 18};
    vecs[4] = '{8'h43, 10, 1'b1, 1, 10, 1, 0, 1'b1, 10, 12};
    vecs[5] = '{8'h43, 0,  1'b0, 1, 0,  1, 0, 1'b1, 10, 2};
    vecs[6] = '{8'h53, 0,  1'b0, 1, 0,  1, 0, 1'b1, 10, 2};
    vecs[7] = '{8'h44, 0,  1'b0, 1, 0,  1, 0, 1'b1, 10, 2};
    vecs[8] = '{8'h00, 0,  1'b0, 1, 0,  0, 1, 1'b1, 10, 0};
    vecs[9] = '{8'h53, 1,  1'b1, 1, 1,  1, 0, 1'b1, 1,  3};

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_outputs", {28'd0, rd_uart, cpu_en, send_signal, cmd_error}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    reset = 1'b1;

    // empty FIFO after release: no fetch, stray data_sent ignored in IDLE
    repeat (5) @(negedge clk);
    manualSent = 1'b1;
    @(negedge clk);
    manualSent = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_fetch", rdCnt, 32'd0);
    check("idle_state", {29'd0, state}, 32'd0);

    for (int i = 0; i < 10; i++) runVector(i);

    // asynchronous reset in WAIT with a second dump byte queued behind
    autoSent = 1'b0;
    rd0 = rdCnt;
    pushByte(8'h44);
    pushByte(8'h44);
    n = 0;
    while (state !== 3'd6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_reached", {29'd0, state}, 32'd6);
    repeat (3) @(negedge clk);
    check("wait_holds", {29'd0, state}, 32'd6);
    check("wait_single_pop", rdCnt - rd0, 32'd1);
    check("wait_byte_queued", {31'd0, rx_empty}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_state", {29'd0, state}, 32'd0);
    check("async_outputs", {28'd0, rd_uart, cpu_en, send_signal, cmd_error}, 32'd0);
    check("async_halted", {31'd0, halted}, 32'd0);
    check("async_cycle_count", cycle_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    autoSent = 1'b1;
    rd0 = rdCnt;
    send0 = sendCnt;
    repeat (20) @(negedge clk);
    check("post_rst_pop", rdCnt - rd0, 32'd1);
    check("post_rst_send", sendCnt - send0, 32'd1);
    check("post_rst_latency", sendIdx - fetchIdx, 32'd2);
    check("post_rst_idle", {29'd0, state}, 32'd0);
    check("post_rst_fifo_empty", {31'd0, rx_empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
